change_dispenser: RTL and testbench

Return-path companion to the vending machine's coin-acceptor next-state logic. The acceptor decodes coins coming in; this block encodes change going out. It takes a change amount in shilling units and drives the coin hopper one coin per valid/ready handshake, using the same 2-bit coin code (01 shilling, 10 crown). It prefers crowns, falls back to shillings, and flags a fault when exact change cannot be paid.

---
 rtl/change_dispenser.sv | 144 ++++++++++++++
 tb/tb_change_dispenser.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: pays a shilling amount as crown/shilling coins over a valid/ready hopper handshake.
// Optional build macro CHANGE_TIMEOUT_EN adds a stall watchdog that faults after ACK_TIMEOUT idle ISSUE cycles.
module change_dispenser #(
    parameter int CREDIT_W    = 4,
    parameter int CROWN_VALUE = 5,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CREDIT_W-1:0] change_amt,
    input  logic                crown_empty,
    input  logic                shilling_empty,
    output logic [1:0]          coin_out,
    output logic                coin_valid,
    input  logic                coin_ready,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [CREDIT_W-1:0] remaining
);
    // state  | meaning
    // IDLE   | waiting for start
    // SELECT | choose next coin from remaining and hopper stock
    // ISSUE  | coin presented, waiting for hopper handshake
    // FAULT  | exact change impossible (or hopper stalled); holds unpaid amount
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ISSUE, S_FAULT} state_t;

    localparam logic [CREDIT_W-1:0] CROWN      = CREDIT_W'(CROWN_VALUE);
    localparam logic [1:0]          COIN_NONE  = 2'b00;
    localparam logic [1:0]          COIN_SHIL  = 2'b01;
    localparam logic [1:0]          COIN_CROWN = 2'b10;

    if (CROWN_VALUE <= 1 || CROWN_VALUE > (2**CREDIT_W) - 1 ||
        ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_param
        $error("change_dispenser: parameter out of range");
    end

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_remaining, w_remaining_nxt;
    logic [1:0]          r_coin, w_coin_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_done, w_done_nxt;
    logic                r_fault, w_fault_nxt;

`ifdef CHANGE_TIMEOUT_EN
    localparam logic [7:0] STALL_LIM = 8'(ACK_TIMEOUT);
    logic [7:0] r_stall, w_stall_nxt;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_coin_nxt      = r_coin;
        w_valid_nxt     = r_valid;
        w_done_nxt      = 1'b0;
        w_fault_nxt     = r_fault;
        case (r_state)
            S_IDLE, S_FAULT: begin
                if (start) begin
                    w_remaining_nxt = change_amt;
                    w_fault_nxt     = 1'b0;
                    w_state_nxt     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_remaining == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_remaining >= CROWN && !crown_empty) begin
                    w_coin_nxt  = COIN_CROWN;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (!shilling_empty) begin
                    w_coin_nxt  = COIN_SHIL;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_fault_nxt = 1'b1;
                    w_coin_nxt  = COIN_NONE;
                    w_state_nxt = S_FAULT;
                end
            end
            S_ISSUE: begin
                if (coin_ready) begin
                    // SELECT only picks a coin no larger than remaining, so no underflow
                    w_remaining_nxt = r_remaining - ((r_coin == COIN_CROWN) ? CROWN : CREDIT_W'(1));
                    w_coin_nxt      = COIN_NONE;
                    w_valid_nxt     = 1'b0;
                    w_state_nxt     = S_SELECT;
                end
`ifdef CHANGE_TIMEOUT_EN
                else if (r_stall == STALL_LIM) begin
                    w_fault_nxt = 1'b1;
                    w_coin_nxt  = COIN_NONE;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_FAULT;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef CHANGE_TIMEOUT_EN
    always_comb begin
        w_stall_nxt = 8'd0;
        if (r_state == S_ISSUE && w_state_nxt == S_ISSUE)
            w_stall_nxt = r_stall + 8'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_coin      <= COIN_NONE;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
            r_stall     <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_coin      <= w_coin_nxt;
            r_valid     <= w_valid_nxt;
            r_done      <= w_done_nxt;
            r_fault     <= w_fault_nxt;
`ifdef CHANGE_TIMEOUT_EN
            r_stall     <= w_stall_nxt;
`endif
        end
    end

    assign coin_out   = r_coin;
    assign coin_valid = r_valid;
    assign busy       = (r_state == S_SELECT) || (r_state == S_ISSUE);
    assign done       = r_done;
    assign fault      = r_fault;
    assign remaining  = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a coin-sequence reference model.
module tb_change_dispenser;
    localparam int CROWN = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] change_amt = 4'd0;
    logic       crown_empty = 1'b0;
    logic       shilling_empty = 1'b0;
    logic [1:0] coin_out;
    logic       coin_valid;
    logic       coin_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       fault;
    logic [3:0] remaining;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int exp_fault;
    int exp_rem;

    change_dispenser dut (
        .clk(clk), .rst_n(rst_n), .start(start), .change_amt(change_amt),
        .crown_empty(crown_empty), .shilling_empty(shilling_empty),
        .coin_out(coin_out), .coin_valid(coin_valid), .coin_ready(coin_ready),
        .busy(busy), .done(done), .fault(fault), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Coin list a cashier would hand out: crowns while they fit, then shillings.
    task automatic model(input int amt, input bit ce, input bit se);
        int r;
        r = amt;
        exp_q.delete();
        exp_fault = 0;
        while (r > 0) begin
            if (r >= CROWN && !ce) begin exp_q.push_back(2); r -= CROWN; end
            else if (!se)          begin exp_q.push_back(1); r -= 1;     end
            else begin exp_fault = 1; break; end
        end
        exp_rem = r;
    endtask

    task automatic pay(input int amt, input bit ce, input bit se,
                       input int first_stall, input int max_stall, input bit poke_start);
        int idx, stall_left, stalls, rem_now;
        bit fin;
        model(amt, ce, se);
        @(negedge clk);
        change_amt = 4'(amt); crown_empty = ce; shilling_empty = se;
        start = 1'b1; coin_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_select", 32'(busy), 1);
        idx = 0; stall_left = first_stall; stalls = 0; fin = 0; rem_now = amt;
        for (int n = 2; n < 300 && !fin; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 2 && exp_q.size() > 0) check("lat_valid", 32'(coin_valid), 1);
            if (done || fault) begin
                fin = 1;
                check("done_fault_excl", 32'(done & fault), 0);
                check("outcome_fault", 32'(fault), exp_fault);
                check("remaining_end", 32'(remaining), exp_rem);
                check("coins_issued", idx, exp_q.size());
                check("valid_end", 32'(coin_valid), 0);
                if (stalls == 0) check("cycles", n, 2 * exp_q.size() + 2);
            end else if (coin_valid) begin
                if (idx < exp_q.size()) check("coin_out", 32'(coin_out), exp_q[idx]);
                else check("extra_coin", idx, exp_q.size());
                check("remaining", 32'(remaining), rem_now);
                if (stall_left > 0) begin
                    coin_ready = 1'b0;
                    stall_left--;
                    stalls++;
                    if (poke_start) begin start = 1'b1; change_amt = 4'($urandom); end
                end else begin
                    coin_ready = 1'b1;
                    if (idx < exp_q.size()) rem_now -= (exp_q[idx] == 2) ? CROWN : 1;
                    idx++;
                    stall_left = $urandom_range(0, max_stall);
                end
            end else begin
                coin_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!fin) check("pay_timeout", 0, 1);
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        check("fault_sticky", 32'(fault), exp_fault);
        check("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        #2;
        check("rst_valid", 32'(coin_valid), 0);
        check("rst_coin", 32'(coin_out), 0);
        check("rst_rem", 32'(remaining), 0);
        check("rst_flags", 32'({busy, done, fault}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pay(7, 0, 0, 0, 0, 0);
        pay(7, 1, 0, 0, 0, 0);
        pay(6, 0, 1, 0, 0, 0);
        pay(0, 0, 0, 0, 0, 0);
        pay(10, 0, 0, 5, 0, 1);
        pay(3, 0, 1, 0, 0, 0);
        pay(15, 0, 0, 0, 0, 0);

        // asynchronous reset while a coin is in flight
        @(negedge clk);
        change_amt = 4'd10; crown_empty = 1'b0; shilling_empty = 1'b0;
        start = 1'b1; coin_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(coin_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(coin_valid), 0);
        check("arst_coin", 32'(coin_out), 0);
        check("arst_rem", 32'(remaining), 0);
        check("arst_flags", 32'({busy, done, fault}), 0);
        @(negedge clk); rst_n = 1'b1;

`ifdef CHANGE_TIMEOUT_EN
        begin
            int hit;
            hit = 0;
            @(negedge clk);
            change_amt = 4'd10; start = 1'b1; coin_ready = 1'b0;
            @(negedge clk); start = 1'b0;
            for (int n = 2; n < 60 && hit == 0; n++) begin
                @(negedge clk);
                if (fault) hit = n;
            end
            check("to_cycle", hit, 2 + 15 + 1);
            check("to_valid", 32'(coin_valid), 0);
            check("to_coin", 32'(coin_out), 0);
            check("to_rem", 32'(remaining), 10);
        end
`endif

        for (int t = 0; t < 40; t++)
            pay($urandom_range(0, 15), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3), 4, $urandom_range(0, 1) == 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
